// File: rtl/sprite_line_renderer_pkg.sv
// Shared types and constants for the scanline sprite compositor.
package sprite_pkg;

  localparam int unsigned N_SPR    = 8;
  localparam int unsigned N_SLOT   = 4;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned SPR_W    = 16;
  localparam logic [11:0] BG_COLOR = 12'h000;

  localparam int unsigned IdxW  = $clog2(N_SPR);
  localparam int unsigned SlotW = $clog2(N_SLOT);
  localparam int unsigned CntW  = $clog2(N_SLOT + 1);

  typedef struct packed {
    logic        en;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [3:0]  pat;
    logic [11:0] color;
  } spr_entry_t;

  typedef struct packed {
    logic [9:0]  x;
    logic [11:0] color;
    logic [15:0] row;
  } slot_t;

  typedef enum logic [1:0] {StIdle, StScan, StFetch, StDone} fsm_t;

  // Unsigned wrap makes lines above the sprite top fail the row-range test too.
  function automatic logic spr_hit(spr_entry_t e, logic [9:0] ly);
    logic [9:0] d;
    d = ly - e.y;
    return e.en && (ly >= e.y) && (d < 10'(SPR_W));
  endfunction

endpackage

// File: rtl/sprite_line_renderer_if.sv
// Timing, sprite-table, pattern-ROM and pixel-stream signals of the renderer.
interface sprite_line_renderer_if;
  import sprite_pkg::*;

  logic            frame_start;
  logic [9:0]      hpos;
  logic [9:0]      line_y;
  logic            line_valid;
  logic            spr_we;
  logic [IdxW-1:0] spr_idx;
  logic [9:0]      spr_x;
  logic [9:0]      spr_y;
  logic [3:0]      spr_pat;
  logic [11:0]     spr_color;
  logic            spr_en;
  logic [7:0]      pat_addr;
  logic [15:0]     pat_data;
  logic [11:0]     pix_color;
  logic            pix_we;
  logic            overflow;

  modport master (
    output frame_start, hpos, line_y, line_valid, spr_we, spr_idx, spr_x, spr_y, spr_pat,
           spr_color, spr_en, pat_data,
    input  pat_addr, pix_color, pix_we, overflow
  );

  modport slave (
    input  frame_start, hpos, line_y, line_valid, spr_we, spr_idx, spr_x, spr_y, spr_pat,
           spr_color, spr_en, pat_data,
    output pat_addr, pix_color, pix_we, overflow
  );

endinterface

// File: rtl/sprite_line_renderer_slot_mux.sv
// Combinational priority pick of the first opaque slot at the given pixel.
module sprite_slot_mux
  import sprite_pkg::*;
(
  input  slot_t             slots_i [N_SLOT],
  input  logic [N_SLOT-1:0] valid_i,
  input  logic [9:0]        hpos_i,
  output logic              hit_o,
  output logic [11:0]       color_o
);

  logic [9:0] off;

  // Walk from the highest slot down so the lowest index overrides.
  always_comb begin
    hit_o   = 1'b0;
    color_o = BG_COLOR;
    off     = '0;
    for (int s = N_SLOT - 1; s >= 0; s--) begin
      off = hpos_i - slots_i[s].x;
      if (valid_i[s] && (hpos_i >= slots_i[s].x) && (off < 10'(SPR_W)) &&
          slots_i[s].row[4'd15 - off[3:0]]) begin
        hit_o   = 1'b1;
        color_o = slots_i[s].color;
      end
    end
  end

endmodule

// File: rtl/sprite_line_renderer.sv
// Scanline sprite compositor: scans the table in hblank, composites the next active line.
module sprite_line_renderer
  import sprite_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  sprite_line_renderer_if.slave         bus_io
);

  spr_entry_t        tbl_q [N_SPR];
  slot_t             shadow_q [N_SLOT];
  slot_t             act_q [N_SLOT];
  fsm_t              state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [9:0]        ly_q, ly_d;
  logic              lv_q, lv_d;
  logic [N_SLOT-1:0] shv_q, shv_d;
  logic [N_SLOT-1:0] actv_q;
  logic              act_lv_q;
  logic              ovf_q, ovf_d;
  logic [7:0]        pat_addr_q, pat_addr_d;
  logic [11:0]       pix_color_q, pix_color_d;
  logic              pix_we_q, pix_we_d;
  logic              store_en, copy_en, clear_act, drop, hit, last;
  logic              mux_hit;
  logic [11:0]       mux_color;
  spr_entry_t        cur;

  assign cur  = tbl_q[idx_q];
  assign hit  = spr_hit(cur, ly_q);
  assign last = (idx_q == IdxW'(N_SPR - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ly_d       = ly_q;
    lv_d       = lv_q;
    shv_d      = shv_q;
    pat_addr_d = pat_addr_q;
    store_en   = 1'b0;
    copy_en    = 1'b0;
    drop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_io.hpos == 10'(H_ACTIVE)) begin
          ly_d    = bus_io.line_y;
          lv_d    = bus_io.line_valid;
          shv_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (hit && (cnt_q < CntW'(N_SLOT))) begin
          pat_addr_d = {cur.pat, 4'(ly_q - cur.y)};
          state_d    = StFetch;
        end else begin
          drop = hit;
          if (last) state_d = StDone;
          else      idx_d   = idx_q + 1'b1;
        end
      end
      StFetch: begin
        store_en                  = 1'b1;
        shv_d[cnt_q[SlotW-1:0]]   = 1'b1;
        cnt_d                     = cnt_q + 1'b1;
        if (last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StScan;
        end
      end
      StDone: begin
        if (bus_io.hpos == 10'(H_TOTAL - 1)) begin
          copy_en = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A line whose blank was never scanned shows no sprites.
  assign clear_act = (bus_io.hpos == 10'(H_TOTAL - 1)) && (state_q != StDone);

  always_comb begin
    ovf_d = ovf_q;
    if (bus_io.frame_start) ovf_d = 1'b0;
    if (drop)               ovf_d = 1'b1;
  end

  sprite_slot_mux u_slot_mux (
    .slots_i (act_q),
    .valid_i (actv_q),
    .hpos_i  (bus_io.hpos),
    .hit_o   (mux_hit),
    .color_o (mux_color)
  );

  always_comb begin
    pix_we_d    = (bus_io.hpos < 10'(H_ACTIVE)) && act_lv_q;
    pix_color_d = (pix_we_d && mux_hit) ? mux_color : BG_COLOR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_SPR; k++) tbl_q[k] <= '0;
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      ly_q        <= '0;
      lv_q        <= 1'b0;
      shv_q       <= '0;
      actv_q      <= '0;
      act_lv_q    <= 1'b0;
      ovf_q       <= 1'b0;
      pat_addr_q  <= '0;
      pix_color_q <= BG_COLOR;
      pix_we_q    <= 1'b0;
    end else begin
      if (bus_io.spr_we) begin
        tbl_q[bus_io.spr_idx] <= '{en: bus_io.spr_en, x: bus_io.spr_x, y: bus_io.spr_y,
                                   pat: bus_io.spr_pat, color: bus_io.spr_color};
      end
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ly_q        <= ly_d;
      lv_q        <= lv_d;
      shv_q       <= shv_d;
      ovf_q       <= ovf_d;
      pat_addr_q  <= pat_addr_d;
      pix_color_q <= pix_color_d;
      pix_we_q    <= pix_we_d;
      if (copy_en) begin
        actv_q   <= shv_q;
        act_lv_q <= lv_q;
      end else if (clear_act) begin
        actv_q   <= '0;
        act_lv_q <= bus_io.line_valid;
      end
    end
  end

  // Slot payloads are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      shadow_q[cnt_q[SlotW-1:0]] <= '{x: cur.x, color: cur.color, row: bus_io.pat_data};
    end
    if (copy_en) act_q <= shadow_q;
  end

  assign bus_io.pat_addr  = pat_addr_d;
  assign bus_io.pix_color = pix_color_q;
  assign bus_io.pix_we    = pix_we_q;
  assign bus_io.overflow  = ovf_q;

endmodule

// File: doc/sprite_line_renderer.md
Name: sprite_line_renderer

Overview:
Per-scanline sprite compositor that generates the pixel stream written into the banded double-buffered VRAM. It holds a small sprite attribute table loaded by the game FSM. During each horizontal blank it selects the sprites that hit the next line and fetches their pattern rows. During the following active line it emits one 12-bit RGB pixel per clock plus a write enable, so the stream can drive the VRAM write port directly.

Parameters:
N_SPR, 8, number of sprite table entries (index width clog2(N_SPR))
N_SLOT, 4, maximum sprites composited per line
H_ACTIVE, 640, active pixels per line
H_TOTAL, 800, total clocks per line
SPR_W, 16, sprite width/height in pixels
BG_COLOR, 12'h000, colour output where no opaque sprite pixel exists

Ports:
clk  in  1  pixel clock (25 MHz domain), single clock
reset  in  1  synchronous, active-high
frame_start  in  1  one-cycle pulse per frame
hpos  in  10  current horizontal scan position, 0..H_TOTAL-1
line_y  in  10  line to be rendered next; sampled when hpos==H_ACTIVE
line_valid  in  1  next line is inside the writable band; sampled with line_y
spr_we  in  1  sprite table write strobe
spr_idx  in  3  table entry written
spr_x  in  10  sprite left x
spr_y  in  10  sprite top y
spr_pat  in  4  pattern number
spr_color  in  12  sprite RGB
spr_en  in  1  entry enable
pat_addr  out  8  {pattern, row[3:0]} to pattern ROM
pat_data  in  16  pattern row, 1-cycle ROM latency, MSB = leftmost pixel
pix_color  out  12  composited pixel
pix_we  out  1  pixel write enable
overflow  out  1  sticky: more than N_SLOT sprites hit a line this frame

Behaviour:
- Reset values: pix_color=BG_COLOR, pix_we=0, overflow=0, pat_addr=0, all table entries disabled, both slot banks empty, FSM=IDLE.
- Table writes: on spr_we, entry spr_idx is updated at the clock edge. A write takes effect for any scan that reads that entry on a later cycle.
- FSM states:
  - IDLE: at hpos==H_ACTIVE, latch line_y/line_valid, clear the shadow slot bank and slot count, set i=0, go to SCAN.
  - SCAN: test entry i. Hit condition: en && line_y>=y && (line_y-y)<SPR_W, using 10-bit unsigned compare.
    - Hit with slots free: drive pat_addr={pat, line_y-y}, go to FETCH.
    - Otherwise, or when slots are full: i++.
    - After i==N_SPR-1 is resolved, go to DONE.
  - FETCH: store {x, color, pat_data} into shadow slot[count], count++, i++, return to SCAN (or DONE if i was last).
  - A hit found while count==N_SLOT is dropped and sets overflow.
  - DONE: wait. At hpos==H_TOTAL-1, copy shadow bank and latched line_valid to the active bank, go to IDLE.
- Scan budget: worst case 2*N_SPR=16 clocks, well inside the 160-clock blank.
- Compositing:
  - For pixel hpos<H_ACTIVE, slot s is opaque if hpos>=x_s, (hpos-x_s)<SPR_W, and bit[15-(hpos-x_s)] is set.
  - The lowest slot index (lowest table index) wins; otherwise BG_COLOR.
  - Latency is 1: pix_color/pix_we registered the cycle after hpos is presented.
  - pix_we=1 iff the delayed hpos<H_ACTIVE and the active line_valid is set; otherwise pix_we=0 and pix_color=BG_COLOR.
- Clipping: pixels with x>=H_ACTIVE are never emitted. A sprite with x in 625..639 is partially drawn. There is no wrap to x=0.
- Overflow: cleared by frame_start. If frame_start and a drop occur in the same cycle, the set wins.
- Reset mid-scan: FSM returns to IDLE and both banks are emptied. The next line after reset outputs only BG_COLOR with pix_we per line_valid.
- hpos discontinuity: if hpos jumps past H_ACTIVE without equality, no scan occurs and the active bank stays empty for that line.

Decomposition:
- Package sprite_pkg: H_ACTIVE, H_TOTAL, SPR_W, typedef spr_entry_t {en, x, y, pat, color}, typedef slot_t {x, color, row[15:0]}, enum fsm_t {IDLE, SCAN, FETCH, DONE}.
- One natural sub-module: sprite_slot_mux (combinational priority pick over N_SLOT slots given hpos, registered in the parent).

Test Plan:
- Reset then 2 lines, table empty, line_valid=1 → pix_we=1 for 640 clocks per line, pix_color=12'h000 throughout, overflow=0.
- Sprite 0 {x=100, y=50, pat=3, color=12'hF00}, ROM row0=16'h8001, line_y=50 → pix_color=F00 only for hpos 100 and 115, one clock after hpos is presented; pat_addr=8'h30 seen during scan.
- Sprites 1 and 2 overlap at x=200 with rows 16'hFFFF, colors 0F0 and 00F → pixels 200..215 are 0F0 (index 1 wins).
- Five enabled sprites on line_y=10 → only indices 0..3 drawn, overflow=1. Pulse frame_start → overflow=0.
- Sprite x=630, row 16'hFFFF → hpos 630..639 coloured; no pix_we after hpos 639; hpos 0 of the next line shows BG_COLOR.
- Assert reset during SCAN (hpos=645), release → next active line is all BG_COLOR, FSM in IDLE; line_valid=0 line → pix_we=0 for the whole line.
